// File: rtl/score_pkg.sv
// Shared types and helpers for the BCD score incrementer.
// Digit width, digit maximum, FSM state type and the all-9s compare.
package score_pkg;

  localparam int BCD_W = 4;
  localparam logic [BCD_W-1:0] BCD_MAX = 4'd9;

  typedef enum logic {
    IDLE  = 1'b0,
    COUNT = 1'b1
  } state_t;

  // True when the low 'digits' nibbles of q are all 9.
  // q is zero-extended by the caller; supports up to 16 digits.
  function automatic logic all_nines(
    input logic [63:0] q,
    input int          digits
  );
    logic r;
    r = 1'b1;
    for (int i = 0; i < 16; i++) begin
      if (i < digits && q[BCD_W*i +: BCD_W] != BCD_MAX)
        r = 1'b0;
    end
    return r;
  endfunction

endpackage

// File: rtl/bcd_digit_inc.sv
// One BCD digit of the increment carry chain (combinational).
// Ports: d/cin in, q/cout out; a 9 with carry-in wraps to 0 and carries.
module bcd_digit_inc
  import score_pkg::*;
(
  input  logic [BCD_W-1:0] d,
  input  logic             cin,
  output logic [BCD_W-1:0] q,
  output logic             cout
);

  always_comb begin
    q    = d;
    cout = 1'b0;
    if (cin) begin
      if (d == BCD_MAX) begin
        q    = '0;
        cout = 1'b1;
      end else begin
        q = d + 4'd1;
      end
    end
  end

endmodule

// File: rtl/bcd_score_incrementer.sv
// Packed-BCD score counter fed by a req/ack point award, one point per
// enabled cycle, with a bonus pulse when digit BONUS_DIGIT advances.
// Ports: clock, clr (sync high), ld/D load, ent/enp enables,
// add_req/add_amt in, add_ack/busy/Q/rco/bonus out.
// Macro SCORE_ROLLOVER_EN: all-9s wraps to 0 with a registered rco pulse;
// undefined, the score saturates at all-9s.
module bcd_score_incrementer
  import score_pkg::*;
#(
  parameter int DIGITS      = 4,
  parameter int BONUS_DIGIT = 3,
  parameter int AMT_W       = 4
) (
  input  logic                  clock,
  input  logic                  clr,
  input  logic                  ld,
  input  logic [4*DIGITS-1:0]   D,
  input  logic                  ent,
  input  logic                  enp,
  input  logic                  add_req,
  input  logic [AMT_W-1:0]      add_amt,
  output logic                  add_ack,
  output logic                  busy,
  output logic [4*DIGITS-1:0]   Q,
  output logic                  rco,
  output logic                  bonus
);

  localparam int QW = 4 * DIGITS;
  localparam int BL = BCD_W * BONUS_DIGIT;

  state_t           state;
  state_t           state_n;
  logic [AMT_W-1:0] rem;
  logic [AMT_W-1:0] rem_n;
  logic [QW-1:0]    q_n;
  logic [QW-1:0]    inc_q;
  logic [QW-1:0]    nxt;
  logic [DIGITS:0]  carry;
  logic             ack_n;
  logic             bonus_n;
  logic             sat;
  logic             all9;
  logic             wrap_n;

  assign carry[0] = 1'b1;

  for (genvar i = 0; i < DIGITS; i++) begin : g_dig
    bcd_digit_inc u_dig (
      .d    (Q[BCD_W*i +: BCD_W]),
      .cin  (carry[i]),
      .q    (inc_q[BCD_W*i +: BCD_W]),
      .cout (carry[i+1])
    );
  end

  // Carry out of the top digit means every digit was 9.
  assign sat  = carry[DIGITS];
  assign all9 = all_nines(64'(Q), DIGITS);
  assign busy = (state == COUNT);

`ifdef SCORE_ROLLOVER_EN
  logic wrap;
  assign nxt = inc_q;
  assign rco = (ent && all9) || wrap;
`else
  assign nxt = sat ? Q : inc_q;
  assign rco = ent && all9;
`endif

  always_comb begin
    state_n = state;
    rem_n   = rem;
    q_n     = Q;
    ack_n   = 1'b0;
    bonus_n = 1'b0;
    wrap_n  = 1'b0;
    if (ld) begin
      q_n     = D;
      state_n = IDLE;
      rem_n   = '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (add_req) begin
            ack_n = 1'b1;
            if (add_amt != '0) begin
              rem_n   = add_amt;
              state_n = COUNT;
            end
          end
        end
        COUNT: begin
          if (ent && enp) begin
            q_n     = nxt;
            rem_n   = rem - AMT_W'(1);
            bonus_n = nxt[BL +: BCD_W] != Q[BL +: BCD_W];
            wrap_n  = sat;
            if (rem == AMT_W'(1))
              state_n = IDLE;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (clr) begin
      state   <= IDLE;
      rem     <= '0;
      Q       <= '0;
      add_ack <= 1'b0;
      bonus   <= 1'b0;
    end else begin
      state   <= state_n;
      rem     <= rem_n;
      Q       <= q_n;
      add_ack <= ack_n;
      bonus   <= bonus_n;
    end
  end

`ifdef SCORE_ROLLOVER_EN
  always_ff @(posedge clock) begin
    if (clr) wrap <= 1'b0;
    else     wrap <= wrap_n;
  end
`else
  // wrap_n only matters with rollover enabled.
  logic unused_wrap;
  assign unused_wrap = wrap_n;
`endif

endmodule

// File: tb/tb_bcd_score_incrementer.sv
// Self-checking bench for bcd_score_incrementer.
// Directed scenarios plus random traffic against a decimal score model.
module tb_bcd_score_incrementer;

  localparam int MAXV = 9999;

  logic        clock = 1'b0;
  logic        clr = 1'b1;
  logic        ld = 1'b0;
  logic [15:0] D = '0;
  logic        ent = 1'b0;
  logic        enp = 1'b0;
  logic        add_req = 1'b0;
  logic [3:0]  add_amt = '0;
  logic        add_ack;
  logic        busy;
  logic [15:0] Q;
  logic        rco;
  logic        bonus;

  int total = 0;
  int bad = 0;

  int m_score = 0;
  int m_left = 0;
  bit m_busy = 0;
  bit m_ack = 0;
  bit m_bonus = 0;
  bit m_wrap = 0;

  bcd_score_incrementer #(
    .DIGITS(4), .BONUS_DIGIT(3), .AMT_W(4)
  ) dut (
    .clock(clock), .clr(clr), .ld(ld), .D(D),
    .ent(ent), .enp(enp), .add_req(add_req),
    .add_amt(add_amt), .add_ack(add_ack),
    .busy(busy), .Q(Q), .rco(rco), .bonus(bonus)
  );

  always #5 clock = ~clock;

  function automatic bit bcd_ok(input logic [15:0] v);
    bit r = 1;
    for (int i = 0; i < 4; i++)
      if (v[4*i +: 4] > 4'd9) r = 0;
    return r;
  endfunction

  always @(posedge clock)
    if (!clr && ld)
      assert (bcd_ok(D)) else $error("illegal BCD load %h", D);

  function automatic int bcd2int(input logic [15:0] v);
    int r = 0;
    for (int i = 3; i >= 0; i--)
      r = r * 10 + int'(v[4*i +: 4]);
    return r;
  endfunction

  function automatic logic [15:0] int2bcd(input int n);
    logic [15:0] r;
    int t = n;
    for (int i = 0; i < 4; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  function automatic int thousands(input int n);
    return (n / 1000) % 10;
  endfunction

  // Score model: integer points, advanced once per clock edge.
  task automatic model_edge();
    int old;
    if (clr) begin
      m_score = 0; m_left = 0; m_busy = 0;
      m_ack = 0; m_bonus = 0; m_wrap = 0;
    end else if (ld) begin
      m_score = bcd2int(D); m_left = 0; m_busy = 0;
      m_ack = 0; m_bonus = 0; m_wrap = 0;
    end else if (m_busy) begin
      m_ack = 0; m_bonus = 0; m_wrap = 0;
      if (ent && enp) begin
        old = m_score;
        if (old == MAXV) begin
`ifdef SCORE_ROLLOVER_EN
          m_score = 0;
          m_wrap = 1;
`endif
        end else begin
          m_score = old + 1;
        end
        m_bonus = thousands(old) != thousands(m_score);
        m_left--;
        if (m_left == 0) m_busy = 0;
      end
    end else begin
      m_bonus = 0; m_wrap = 0;
      m_ack = add_req;
      if (add_req && add_amt != 0) begin
        m_left = int'(add_amt);
        m_busy = 1;
      end
    end
  endtask

  function automatic logic [19:0] exp_vec();
    logic r;
    r = (ent && m_score == MAXV) || m_wrap;
    return {int2bcd(m_score), m_busy, m_ack, m_bonus, r};
  endfunction

  function automatic logic [19:0] obs_vec();
    return {Q, busy, add_ack, bonus, rco};
  endfunction

  task automatic tick();
    @(posedge clock);
    model_edge();
    #1;
  endtask

  task automatic test_reset();
    clr = 1;
    tick();
    tick();
    total++;
    if (obs_vec() !== exp_vec()) begin
      bad++;
      $display("FAIL reset got=%h need=%h", obs_vec(), exp_vec());
    end
    total++;
    if ({Q, busy, add_ack, bonus} !== 19'h0) begin
      bad++;
      $display("FAIL reset_zero got=%h need=0",
               {Q, busy, add_ack, bonus});
    end
    clr = 0;
  endtask

  task automatic test_basic();
    int nbusy = 0;
    ent = 1; enp = 1;
    add_req = 1; add_amt = 4'd5;
    tick();
    add_req = 0;
    total++;
    if (obs_vec() !== exp_vec() || add_ack !== 1'b1) begin
      bad++;
      $display("FAIL basic_ack got=%h need=%h", obs_vec(), exp_vec());
    end
    nbusy += busy;
    for (int i = 0; i < 6; i++) begin
      tick();
      nbusy += busy;
      total++;
      if (obs_vec() !== exp_vec()) begin
        bad++;
        $display("FAIL basic c%0d got=%h need=%h",
                 i, obs_vec(), exp_vec());
      end
    end
    total++;
    if (Q !== 16'h0005 || busy !== 1'b0 || nbusy != 5) begin
      bad++;
      $display("FAIL basic_end got=%h/%0d need=0005/5", Q, nbusy);
    end
  endtask

  task automatic test_carry_bonus();
    int nb = 0;
    int nr = 0;
    ld = 1; D = 16'h0998;
    tick();
    ld = 0;
    add_req = 1; add_amt = 4'd3;
    tick();
    add_req = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      nb += bonus;
      nr += rco;
      total++;
      if (obs_vec() !== exp_vec()) begin
        bad++;
        $display("FAIL carry c%0d got=%h need=%h",
                 i, obs_vec(), exp_vec());
      end
    end
    total++;
    if (Q !== 16'h1001 || nb != 1 || nr != 0) begin
      bad++;
      $display("FAIL carry_end got=%h b%0d r%0d need=1001 b1 r0",
               Q, nb, nr);
    end
  endtask

  task automatic test_pause();
    int nbusy = 0;
    int nack = 0;
    logic [15:0] start;
    bit pat [6] = '{1, 0, 0, 1, 1, 1};
    start = Q;
    add_req = 1; add_amt = 4'd4;
    tick();
    nbusy += busy;
    for (int i = 0; i < 6; i++) begin
      enp = pat[i];
      tick();
      nbusy += busy;
      nack += add_ack;
      total++;
      if (obs_vec() !== exp_vec()) begin
        bad++;
        $display("FAIL pause c%0d got=%h need=%h",
                 i, obs_vec(), exp_vec());
      end
    end
    add_req = 0; enp = 1;
    total++;
    if (bcd2int(Q) != bcd2int(start) + 4 || nbusy != 6 || nack != 0) begin
      bad++;
      $display("FAIL pause_end got=%h busy%0d ack%0d need=+4 6 0",
               Q, nbusy, nack);
    end
    tick();
  endtask

  task automatic test_zero_abort();
    logic [15:0] start;
    start = Q;
    add_req = 1; add_amt = 4'd0;
    tick();
    add_req = 0;
    total++;
    if (add_ack !== 1'b1 || busy !== 1'b0 || Q !== start) begin
      bad++;
      $display("FAIL zero got=%b%b %h need=10 %h",
               add_ack, busy, Q, start);
    end
    tick();
    add_req = 1; add_amt = 4'd9;
    tick();
    add_req = 0;
    tick();
    tick();
    ld = 1; D = 16'h0042;
    tick();
    ld = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if (obs_vec() !== exp_vec()) begin
        bad++;
        $display("FAIL abort c%0d got=%h need=%h",
                 i, obs_vec(), exp_vec());
      end
    end
    total++;
    if (Q !== 16'h0042 || busy !== 1'b0) begin
      bad++;
      $display("FAIL abort_end got=%h/%b need=0042/0", Q, busy);
    end
  endtask

  task automatic test_saturation();
    int nb = 0;
    ld = 1; D = 16'h9998;
    tick();
    ld = 0;
    add_req = 1; add_amt = 4'd5;
    tick();
    add_req = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      nb += bonus;
      total++;
      if (obs_vec() !== exp_vec()) begin
        bad++;
        $display("FAIL sat c%0d got=%h need=%h",
                 i, obs_vec(), exp_vec());
      end
    end
    total++;
`ifdef SCORE_ROLLOVER_EN
    if (Q !== 16'h0003 || busy !== 1'b0 || nb != 1) begin
      bad++;
      $display("FAIL sat_end got=%h b%0d need=0003 b1", Q, nb);
    end
`else
    if (Q !== 16'h9999 || busy !== 1'b0 || nb != 0 || rco !== 1'b1) begin
      bad++;
      $display("FAIL sat_end got=%h b%0d r%b need=9999 b0 r1",
               Q, nb, rco);
    end
`endif
  endtask

  task automatic test_priority();
    add_req = 1; add_amt = 4'd5;
    tick();
    add_req = 0;
    tick();
    clr = 1; ld = 1; D = 16'h1234;
    add_req = 1; add_amt = 4'd3;
    tick();
    total++;
    if (obs_vec() !== exp_vec() || {Q, busy, add_ack} !== 18'h0) begin
      bad++;
      $display("FAIL prio got=%h need=%h", obs_vec(), exp_vec());
    end
    clr = 0; ld = 0; add_req = 0;
    tick();
    total++;
    if (obs_vec() !== exp_vec()) begin
      bad++;
      $display("FAIL prio_after got=%h need=%h", obs_vec(), exp_vec());
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      clr = ($urandom_range(0, 59) == 0);
      ld = ($urandom_range(0, 24) == 0);
      D = int2bcd($urandom_range(0, MAXV));
      if ($urandom_range(0, 7) == 0) D = 16'h9997;
      ent = ($urandom_range(0, 7) != 0);
      enp = ($urandom_range(0, 5) != 0);
      add_req = ($urandom_range(0, 2) == 0);
      add_amt = 4'($urandom_range(0, 15));
      tick();
      total++;
      if (obs_vec() !== exp_vec()) begin
        bad++;
        $display("FAIL rand c%0d got=%h need=%h",
                 i, obs_vec(), exp_vec());
      end
    end
    clr = 0; ld = 0; add_req = 0;
    ent = 1; enp = 1;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_carry_bonus();
    test_pause();
    test_zero_abort();
    test_saturation();
    test_priority();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
